uart_rcv: RTL and testbench

UART_RCV -- requirements
Module: uart_rcv

---
 rtl/uart_rcv.sv | 115 +++++++++++
 tb/tb_uart_rcv.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rcv.sv
// uart_rcv -- 8N1 serial receiver, LSB first, oversampled by a free clock.
//
// One bit period is BAUD_CNT clocks (even, at least 4). After a falling edge
// on the synchronised line the receiver samples at the middle of the start
// bit, then once per bit period for the eight data bits and the stop bit. It
// returns to idle at mid-stop, so a start edge that follows the stop bit
// directly is still caught.
//
// Ports
//   clk      in   sole clock, rising edge
//   rst      in   synchronous, active-high reset
//   RX       in   asynchronous serial line, idle high
//   clr_rdy  in   consumer acknowledge: clears rdy, frm_err and ovr_err
//   rx_data  out  last received byte (changes only when a byte completes)
//   rdy      out  a new byte is available; sticky until clr_rdy
//   frm_err  out  the stop bit of the last byte was sampled low
//   ovr_err  out  a byte completed while rdy was still set
module uart_rcv #(
  parameter int BAUD_CNT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       ovr_err
);

  localparam int CNT_W = $clog2(BAUD_CNT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BAUD_CNT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BAUD_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RCV  = 1'b1
  } state_t;

  logic             rx_p0;
  logic             rx_sync;
  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [3:0]       bit_idx;
  logic [7:0]       shift_reg;

  // Stage p0 -> sync: two-flop synchroniser, resets to the idle level
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0   <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_p0   <= RX;
      rx_sync <= rx_p0;
    end
  end

  // Stage sync -> frame: bit timing, data shift and output flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rdy       <= 1'b0;
      frm_err   <= 1'b0;
      ovr_err   <= 1'b0;
    end else begin
      // Acknowledge first; a byte completing on the same edge overrides below.
      if (clr_rdy) begin
        rdy     <= 1'b0;
        frm_err <= 1'b0;
        ovr_err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rx_sync) begin
            state    <= RCV;
            baud_cnt <= HALF_M1;
            bit_idx  <= '0;
          end
        end

        RCV: begin
          if (baud_cnt == '0) begin
            baud_cnt <= FULL_M1;
            bit_idx  <= bit_idx + 4'd1;
            if (bit_idx == 4'd0) begin
              // Line back high at mid-start: a glitch, not a frame.
              if (rx_sync) state <= IDLE;
            end else if (bit_idx == 4'd9) begin
              state   <= IDLE;
              rx_data <= shift_reg;
              rdy     <= 1'b1;
              frm_err <= ~rx_sync;
              // An acknowledge on the completion edge consumes the old byte,
              // so this one is not an overrun.
              ovr_err <= ~clr_rdy & (ovr_err | rdy);
            end else begin
              shift_reg <= {rx_sync, shift_reg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt - CNT_ONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rcv.sv
// tb_uart_rcv -- directed bench for uart_rcv at 868 clocks per bit.
//
// A frame-level model predicts the output registers: each frame the bench
// drives is entered in a queue with the cycle its byte must appear, derived
// from the edge time, the two-flop synchroniser delay and the bit timing.
// The outputs are compared against the model on every cycle, and literal
// expectations for each scenario pin the model itself.
module tb_uart_rcv;

  localparam int B   = 868;
  localparam int H   = B / 2;
  localparam int LAT = 8247;  // 434 + 9*868 + 1 cycles from start detect to rdy

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       RX = 1'b1;
  logic       clr_rdy = 1'b0;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       ovr_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         due;
    logic [7:0] b;
    logic       stop;
  } ev_t;

  ev_t        q[$];
  ev_t        ev;
  logic [7:0] m_data = '0;
  logic       m_rdy = 1'b0;
  logic       m_frm = 1'b0;
  logic       m_ovr = 1'b0;
  bit         armed = 1'b0;
  int         last_t0 = 0;
  int         rise_cyc = 0;
  logic       prev_rdy;

  uart_rcv #(.BAUD_CNT(B)) dut (
    .clk     (clk),
    .rst     (rst),
    .RX      (RX),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err),
    .ovr_err (ovr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: the output registers as seen in the cycle that begins at this edge.
  always @(posedge clk) begin
    cyc   = cyc + 1;
    armed = 1'b1;
    if (rst) begin
      m_data = '0;
      m_rdy  = 1'b0;
      m_frm  = 1'b0;
      m_ovr  = 1'b0;
      q.delete();
    end else if (q.size() > 0 && q[0].due == cyc) begin
      ev = q.pop_front();
      if (clr_rdy) m_ovr = 1'b0;
      else if (m_rdy) m_ovr = 1'b1;
      m_data = ev.b;
      m_frm  = ~ev.stop;
      m_rdy  = 1'b1;
    end else if (clr_rdy) begin
      m_rdy = 1'b0;
      m_frm = 1'b0;
      m_ovr = 1'b0;
    end
  end

  // Compare every cycle, mid-cycle.
  always @(negedge clk) begin
    if (armed) begin
      chk($sformatf("cycle%0d", cyc),
          {21'b0, rdy, frm_err, ovr_err, rx_data},
          {21'b0, m_rdy, m_frm, m_ovr, m_data});
      if (rdy === 1'b1 && prev_rdy !== 1'b1) rise_cyc = cyc;
      prev_rdy = rdy;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1; clr_rdy = 1'b1;
    @(posedge clk); #1; clr_rdy = 1'b0;
  endtask

  // Drive one 8N1 frame. clr_done raises clr_rdy for the completion edge;
  // abort_bit >= 0 pulses rst in the middle of that bit index and stops.
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input bit clr_done, input int abort_bit);
    logic [9:0] fb;
    int         due;
    fb  = {stop, b, 1'b0};
    due = 0;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < B; c++) begin
        @(posedge clk); #1;
        if (i == abort_bit && c == H) begin
          RX  = 1'b1;
          rst = 1'b1;
          @(posedge clk); #1;
          rst = 1'b0;
          return;
        end
        RX = fb[i];
        if (i == 0 && c == 0) begin
          last_t0 = cyc + 2;
          due     = cyc + 2 + H + 9 * B + 1;
          q.push_back('{due, b, stop});
        end
        clr_rdy = clr_done && (cyc == due - 1);
      end
    end
    @(posedge clk); #1;
    RX      = 1'b1;
    clr_rdy = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_outputs", {21'b0, rx_data, rdy, frm_err, ovr_err}, 32'h0);
    idle(5);

    send_frame(8'hA5, 1'b1, 1'b0, -1);
    idle(20);
    chk("a5_latency", rise_cyc - last_t0, LAT);
    chk("a5_out", {21'b0, rx_data, rdy, frm_err, ovr_err}, {21'b0, 8'hA5, 3'b100});
    pulse_clr();
    chk("a5_clr", {31'b0, rdy}, 32'h0);

    send_frame(8'h3C, 1'b0, 1'b0, -1);
    idle(20);
    chk("3c_out", {21'b0, rx_data, rdy, frm_err, ovr_err}, {21'b0, 8'h3C, 3'b110});
    pulse_clr();
    chk("3c_clr", {21'b0, rx_data, rdy, frm_err, ovr_err}, {21'b0, 8'h3C, 3'b000});

    @(posedge clk); #1;
    RX = 1'b0;
    idle(200);
    RX = 1'b1;
    idle(600);
    chk("glitch_no_rdy", {21'b0, rx_data, rdy, frm_err, ovr_err}, {21'b0, 8'h3C, 3'b000});

    send_frame(8'h5A, 1'b1, 1'b0, -1);
    idle(20);
    chk("5a_latency", rise_cyc - last_t0, LAT);
    chk("5a_out", {21'b0, rx_data, rdy, frm_err, ovr_err}, {21'b0, 8'h5A, 3'b100});
    pulse_clr();

    send_frame(8'h00, 1'b1, 1'b0, -1);
    send_frame(8'hFF, 1'b1, 1'b0, -1);
    idle(20);
    chk("b2b_overrun", {21'b0, rx_data, rdy, frm_err, ovr_err}, {21'b0, 8'hFF, 3'b101});

    send_frame(8'h81, 1'b1, 1'b1, -1);
    idle(20);
    chk("81_clr_coincide", {21'b0, rx_data, rdy, frm_err, ovr_err}, {21'b0, 8'h81, 3'b100});

    send_frame(8'hC3, 1'b1, 1'b0, 5);
    chk("c3_reset", {21'b0, rx_data, rdy, frm_err, ovr_err}, 32'h0);
    idle(20);
    chk("c3_no_rdy", {31'b0, rdy}, 32'h0);

    send_frame(8'h42, 1'b1, 1'b0, -1);
    idle(20);
    chk("42_latency", rise_cyc - last_t0, LAT);
    chk("42_out", {21'b0, rx_data, rdy, frm_err, ovr_err}, {21'b0, 8'h42, 3'b100});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
